// File: rtl/gcd_sched_pkg.sv
// gcd_sched_pkg: shared state encoding and default sizes for the GCD round-robin scheduler.
package gcd_sched_pkg;
    localparam int DEF_DW      = 16;
    localparam int DEF_NUM_REQ = 4;
    localparam int ST_W        = 3;
    typedef enum logic [ST_W-1:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        GUARD  = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;
endpackage

// File: rtl/gcd_rr_pick.sv
// gcd_rr_pick: combinational round-robin selector; first set request at or above ptr, with wrap-around.
module gcd_rr_pick
    import gcd_sched_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = IW'((int'(ptr) + k) % N);
                any = 1'b1;
            end
        end
    end
    assign grant = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/gcd_rr_scheduler.sv
// gcd_rr_scheduler: shares one external GCD core between NUM_REQ requesters in round-robin order.
// Optional GCD_SCHED_ZERO_BYPASS_EN answers jobs with a zero operand directly, without the core.
module gcd_rr_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_data,
    output logic                  gcd_start,
    output logic [DW-1:0]         gcd_a,
    output logic [DW-1:0]         gcd_b,
    input  logic                  gcd_valid,
    input  logic [DW-1:0]         gcd_out,
    output logic                  busy
);
    state_t               state, state_nxt;
    logic [IDW-1:0]       ptr, pick_idx, id_q;
    logic [NUM_REQ-1:0]   grant;
    logic                 any, xfer, zero_op, in_job;
    logic [DW-1:0]        a_q, b_q, res_q, sel_a, sel_b;

    gcd_rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (any)
    );

    always_comb begin
        sel_a = req_a[int'(pick_idx)*DW +: DW];
        sel_b = req_b[int'(pick_idx)*DW +: DW];
    end

`ifdef GCD_SCHED_ZERO_BYPASS_EN
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign xfer = (state == IDLE) && any;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any ? (zero_op ? RESP : LAUNCH) : IDLE;
            LAUNCH:  state_nxt = GUARD;
            GUARD:   state_nxt = WAIT;
            WAIT:    state_nxt = gcd_valid ? RESP : WAIT;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            id_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                a_q  <= sel_a;
                b_q  <= sel_b;
                id_q <= pick_idx;
                ptr  <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDW'(1);
            end
            if (xfer && zero_op)
                res_q <= sel_a | sel_b;
            else if (state == WAIT && gcd_valid)
                res_q <= gcd_out;
        end
    end

    // req_ready is gated by rst_n so every output reads zero while reset is held.
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign in_job    = (state == LAUNCH) || (state == GUARD) || (state == WAIT);
    assign gcd_start = (state == LAUNCH);
    assign gcd_a     = in_job ? a_q : '0;
    assign gcd_b     = in_job ? b_q : '0;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = res_q;
    assign busy      = (state != IDLE);
endmodule
